// File: rtl/seq_cla_adder_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract unit:
// FSM encoding, slice width, opcodes and the signed-overflow rule.
package seq_cla_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Same-sign operands producing an opposite-sign result is the overflow case.
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/seq_cla_adder_cla4.sv
// 4-bit carry-lookahead slice: generate/propagate terms with fully expanded
// carry equations so the carry-out does not ripple through the nibble.
module CLA_4Adder
    import seq_cla_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] p_s;
    logic [SLICE_W-1:0] g_s;
    logic [SLICE_W:0]   c_s;

    // Lookahead carry network and sum bits.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = ci;
        c_s[1] = g_s[0] | (p_s[0] & ci);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & ci);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
        s      = p_s ^ c_s[SLICE_W-1:0];
        co     = c_s[SLICE_W];
    end

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CLA slice is reused over WIDTH/4
// cycles, carry chained through a register, with valid/ready on both sides.
module seq_cla_adder
    import seq_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / SLICE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic               carry_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic               out_valid_r;

    logic [SLICE_W-1:0] nib_a_s;
    logic [SLICE_W-1:0] nib_b_s;
    logic [SLICE_W-1:0] nib_sum_s;
    logic               nib_co_s;
    logic [WIDTH-1:0]   sum_nxt_s;
    logic               last_s;
    logic               accept_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

    CLA_4Adder u_slice (
        .a  (nib_a_s),
        .b  (nib_b_s),
        .ci (carry_r),
        .s  (nib_sum_s),
        .co (nib_co_s)
    );

    // Select the current operand nibbles and merge the slice result into the sum.
    always_comb begin
        accept_s  = in_valid && in_ready;
        last_s    = (cnt_r == CW'(NIB - 1));
        nib_a_s   = opa_r[SLICE_W*int'(cnt_r) +: SLICE_W];
        nib_b_s   = opb_r[SLICE_W*int'(cnt_r) +: SLICE_W];
        sum_nxt_s = sum_r;
        sum_nxt_s[SLICE_W*int'(cnt_r) +: SLICE_W] = nib_sum_s;
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Operand capture, nibble iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            opa_r       <= '0;
            opb_r       <= '0;
            carry_r     <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        opa_r   <= a;
                        opb_r   <= (op_sub == OP_SUB) ? ~b : b;
                        carry_r <= (op_sub == OP_SUB) ? 1'b1 : cin;
                        sum_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_nxt_s;
                    carry_r <= nib_co_s;
                    if (last_s) begin
                        cnt_r       <= '0;
                        cout_r      <= nib_co_s;
                        ovf_r       <= signed_ovf(opa_r[WIDTH-1], opb_r[WIDTH-1], nib_sum_s[SLICE_W-1]);
                        zero_r      <= (sum_nxt_s == '0);
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed bench for seq_cla_adder: a cycle-level reference model of the
// handshake plus arithmetic, checked every cycle, and literal expectations.
module tb_seq_cla_adder;

    localparam int W    = 16;
    localparam int NIB  = W / 4;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;
    logic armed = 1'b0;

    seq_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, zero, cout, sum}
    function automatic logic [W+2:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
        logic [W:0]   u;
        logic [W-1:0] r;
        logic         co;
        int           sx;
        int           sy;
        int           sr;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
            sr = sx - sy;
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            co = u[W];
            sr = sx + sy + (c ? 1 : 0);
        end
        r = u[W-1:0];
        return {((sr > SMAX) || (sr < SMIN)), (r == '0), co, r};
    endfunction

    int           m_phase;
    logic         m_chk;
    logic [W+2:0] m_res;
    logic [W+2:0] m_pend;

    // Model: phase 0 idle, 1..NIB busy, NIB+1 result presented.
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_chk   <= 1'b1;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_pend  <= ref_op(a, b, cin, op_sub);
                m_chk   <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase <= NIB) begin
            if (m_phase == NIB) begin
                m_res <= m_pend;
                m_chk <= 1'b1;
            end
            m_phase <= m_phase + 1;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == 0));
            check("out_valid", 32'(out_valid), 32'(m_phase == NIB + 1));
            if (m_chk) begin
                check("sum", 32'(sum), 32'(m_res[W-1:0]));
                check("cout", 32'(cout), 32'(m_res[W]));
                check("zero", 32'(zero), 32'(m_res[W+1]));
                check("ovf", 32'(ovf), 32'(m_res[W+2]));
            end
        end
    end

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez, input int hold);
        int lat;
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc; op_sub = ts;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = 16'h5A5A; cin = ~tc; op_sub = ~ts;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 3 * NIB) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(NIB));
        check({tag, ".sum"},  32'(sum),  32'(es));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".ovf"},  32'(ovf),  32'(eo));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check({tag, ".held_sum"}, 32'(sum), 32'(es));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ready_after"}, 32'(in_ready), 32'd1);
        check({tag, ".valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_valid;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.flags", {29'd0, cout, ovf, zero}, 32'd0);

        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("add_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
        run_op("bp_hold",  16'hA5A5, 16'h1111, 1'b0, 1'b0, 16'hB6B6, 1'b0, 1'b0, 1'b0, 5);
        run_op("b2b_sub",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);

        // Abort an operation with reset on the second RUN edge.
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.sum", 32'(sum), 32'd0);
        check("abort.flags", {29'd0, cout, ovf, zero}, 32'd0);
        saw_valid = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw_valid++;
        end
        check("abort.no_valid", 32'(saw_valid), 32'd0);
        run_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_cla_adder.md
Name: seq_cla_adder

Overview:
Multi-cycle WIDTH-bit add/subtract unit for the execute stage. It reuses a single 4-bit carry-lookahead slice over WIDTH/4 cycles. The block sequences operand nibbles into the slice, chains each slice's carry-out back as the next carry-in, and assembles the sum plus flags. It uses a valid/ready handshake on both sides so the pipeline can stall around it.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, derived; number of slice iterations. Not overridable.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and opcode valid.
in_ready  output  1  unit can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used only when op_sub=0.
op_sub  input  1  0: A+B+cin; 1: A+~B+1.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
ovf  output  1  two's-complement signed overflow.
zero  output  1  sum == 0.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=0, RUN=1, DONE=2. Value 3 is illegal and recovers to IDLE on the next edge.
- Reset (rst=1 at an edge): state goes to IDLE and the nibble counter goes to 0. sum, cout, ovf and zero all reset to 0. out_valid resets to 0.
- Reset applied in RUN or DONE aborts the operation. The partial or held result is discarded and no out_valid is produced.
- in_ready = (state==IDLE). It is combinational from state only and does not depend on in_valid.
- Accept: at an edge where in_valid and in_ready are both 1, latch the following:
  - a into opA.
  - b into opB; when op_sub=1, store ~b instead.
  - The carry register: cin when op_sub=0, 1 when op_sub=1.
  - Clear sum and the counter, then go to RUN.
- RUN, on each edge with counter=k:
  - Slice inputs are opA[4k+3:4k], opB[4k+3:4k] and the carry register.
  - The slice sum is written to sum[4k+3:4k]; the slice carry-out is written to the carry register.
  - The counter increments.
- On the edge where k=NIB-1, transition to DONE. At the same edge:
  - cout is set to the final carry.
  - ovf = (opA[WIDTH-1]==opB[WIDTH-1]) && (slice sum MSB != opA[WIDTH-1]), where opB is the inverted form when subtracting.
  - zero is computed on the fully assembled sum, including the final nibble.
- Latency: out_valid rises exactly NIB edges after the accept edge (4 for WIDTH=16).
- DONE: out_valid=1. sum, cout, ovf and zero are held stable while out_ready=0, for any number of cycles.
- Leaving DONE: at an edge with out_ready=1, go to IDLE and drop out_valid. The outputs keep their last values but are meaningless while out_valid=0.
- Throughput: one operation per NIB+2 cycles at full rate. There is no accept in the same cycle as a DONE handoff; in_ready stays 0 in DONE.
- in_valid seen in RUN or DONE is ignored. The upstream stage must hold its request until in_ready.
- out_ready seen outside DONE is ignored.
- Wrap-around: sum is modulo 2^WIDTH. The carry out of the MSB appears only on cout.
- Operands are captured, so changes on a, b, cin or op_sub after the accept edge have no effect.

Decomposition:
- Shared package holds:
  - The state encoding constants: ST_IDLE, ST_RUN, ST_DONE.
  - The slice width constant SLICE_W=4.
  - The opcode constants OP_ADD=0 and OP_SUB=1.
- One sub-module: the team's existing 4-bit carry-lookahead slice, CLA_4Adder, instantiated once. It takes nibble A, nibble B and the carry, and returns the nibble sum and carry-out. No other hierarchy.
- The counter, the state register and the result/flag registers live in this block.

Test Plan:
- ADD 0x1234 + 0x4321, cin=0 -> after 4 cycles out_valid=1, sum=0x5555, cout=0, ovf=0, zero=0. in_ready=0 for those 4 cycles plus the DONE cycle.
- ADD 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Also ADD 0x00FF + 0x0000 with cin=1 -> sum=0x0100 (carry ripples across the nibble boundary).
- ADD 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
- SUB 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0. SUB 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1. Check that cin is ignored for SUB by driving cin=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum and flags stable, in_ready=0. Raise out_ready -> next edge IDLE, in_ready=1. Then a back-to-back op is accepted on the following edge.
- Reset mid-op: assert rst at the second RUN edge -> the next cycle is IDLE with all outputs 0. No out_valid appears afterwards, and a new ADD 0x0001 + 0x0001 returns 0x0002 with normal latency.
